// File: rtl/instr_fetch_if.sv
// instr_fetch bus: PC in, memory request/response, flush, decode out.
// slave = fetch unit view, master = surrounding pipeline/memory view.
interface instr_fetch_if;
  logic [31:0] pc_in;
  logic        pc_valid;
  logic        pc_ready;
  logic        mem_req_valid;
  logic [31:0] mem_req_addr;
  logic        mem_req_ready;
  logic        mem_resp_valid;
  logic [31:0] mem_resp_data;
  logic        flush;
  logic        instr_valid;
  logic [31:0] instr_data;
  logic [31:0] instr_pc;
  logic        instr_misalign;
  logic        instr_ready;

  modport slave (
    input  pc_in, pc_valid, mem_req_ready,
    input  mem_resp_valid, mem_resp_data,
    input  flush, instr_ready,
    output pc_ready, mem_req_valid, mem_req_addr,
    output instr_valid, instr_data, instr_pc,
    output instr_misalign
  );

  modport master (
    output pc_in, pc_valid, mem_req_ready,
    output mem_resp_valid, mem_resp_data,
    output flush, instr_ready,
    input  pc_ready, mem_req_valid, mem_req_addr,
    input  instr_valid, instr_data, instr_pc,
    input  instr_misalign
  );
endinterface

// File: rtl/instr_fetch.sv
// Fetch unit: one outstanding imem read, results queued for decode.
// Ports: clk, reset (sync, active-high), bus (instr_fetch_if.slave).
module instr_fetch #(
  parameter int DEPTH = 2
) (
  input  logic          clk,
  input  logic          reset,
  instr_fetch_if.slave  bus
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0]   L_FULL = (AW+1)'(DEPTH);
  localparam logic [AW:0]   L_CONE = (AW+1)'(1);
  localparam logic [AW-1:0] L_PONE = (AW)'(1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_DRAIN
  } state_t;

  state_t      r_state;
  state_t      w_next;
  logic [31:0] r_pc;
  logic        r_discard;

  logic [31:0] r_fd [DEPTH];
  logic [31:0] r_fp [DEPTH];
  logic        r_fm [DEPTH];
  logic [AW-1:0] r_head;
  logic [AW-1:0] r_tail;
  logic [AW:0]   r_count;
  logic [AW:0]   w_cnt_nxt;
  logic          r_valid;

  logic        w_pc_ready;
  logic        w_req_valid;
  logic [31:0] w_req_addr;
  logic        w_accept;
  logic        w_req_fire;
  logic        w_push;
  logic        w_pop;

  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:  if (w_accept) w_next = S_REQ;
      S_REQ:
        if (bus.mem_req_ready)
          w_next = (bus.flush || r_discard) ? S_DRAIN : S_WAIT;
      // A response coinciding with flush is simply dropped.
      S_WAIT:
        if (bus.mem_resp_valid) w_next = S_IDLE;
        else if (bus.flush)     w_next = S_DRAIN;
      S_DRAIN: if (bus.mem_resp_valid) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Slot is reserved at accept time, so a push never sees a full FIFO.
  always_comb begin
    w_pc_ready  = 1'b0;
    w_req_valid = 1'b0;
    w_req_addr  = '0;
    unique case (r_state)
      S_IDLE:
        w_pc_ready = !reset && !bus.flush
                  && (r_count < L_FULL);
      S_REQ: begin
        w_req_valid = 1'b1;
        w_req_addr  = {r_pc[31:2], 2'b00};
      end
      default: ;
    endcase
  end

  assign w_accept   = w_pc_ready && bus.pc_valid;
  assign w_req_fire = w_req_valid && bus.mem_req_ready;
  assign w_push     = (r_state == S_WAIT) && bus.mem_resp_valid
                   && !bus.flush;
  assign w_pop      = bus.instr_ready && r_valid && !bus.flush;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_pc      <= '0;
      r_discard <= 1'b0;
    end else begin
      if (w_accept) r_pc <= bus.pc_in;
      // Remembers a flush that hit while the request was still pending.
      if (w_req_fire)
        r_discard <= 1'b0;
      else if ((r_state == S_REQ) && bus.flush)
        r_discard <= 1'b1;
    end
  end

  always_comb begin
    w_cnt_nxt = r_count;
    if (bus.flush)
      w_cnt_nxt = '0;
    else if (w_push && !w_pop)
      w_cnt_nxt = r_count + L_CONE;
    else if (w_pop && !w_push)
      w_cnt_nxt = r_count - L_CONE;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
      r_valid <= 1'b0;
    end else begin
      r_count <= w_cnt_nxt;
      r_valid <= (w_cnt_nxt != '0);
      if (bus.flush) begin
        r_head <= '0;
        r_tail <= '0;
      end else begin
        if (w_push) r_tail <= r_tail + L_PONE;
        if (w_pop)  r_head <= r_head + L_PONE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_fd[r_tail] <= bus.mem_resp_data;
      r_fp[r_tail] <= r_pc;
      r_fm[r_tail] <= (r_pc[1:0] != 2'b00);
    end
  end

  assign bus.pc_ready       = w_pc_ready;
  assign bus.mem_req_valid  = w_req_valid;
  assign bus.mem_req_addr   = w_req_addr;
  assign bus.instr_valid    = r_valid;
  assign bus.instr_data     = r_valid ? r_fd[r_head] : '0;
  assign bus.instr_pc       = r_valid ? r_fp[r_head] : '0;
  assign bus.instr_misalign = r_valid && r_fm[r_head];

endmodule

// File: doc/instr_fetch.md
# instr_fetch

Instruction fetch unit sitting between the PC register and instruction memory. It accepts fetch addresses from the PC, issues one read request at a time to the memory port, and buffers the returned instruction words with their addresses in a small FIFO for the decode stage. A flush input discards buffered and in-flight fetches when the decoder redirects the PC.

## Interface
- DEPTH, 2: output FIFO entries; power of two, at least 2.
- clk  input  1  clock; all state changes on the rising edge.
- reset  input  1  synchronous, active-high reset.
- pc_in  input  32  fetch address from the PC register.
- pc_valid  input  1  pc_in holds a fetch address.
- pc_ready  output  1  the unit accepts pc_in this cycle.
- mem_req_valid  output  1  read request to instruction memory.
- mem_req_addr  output  32  word-aligned request address.
- mem_req_ready  input  1  memory accepts the request.
- mem_resp_valid  input  1  read data returned; in order, one per accepted request.
- mem_resp_data  input  32  instruction word.
- flush  input  1  discard all buffered and outstanding fetches.
- instr_valid  output  1  FIFO head holds an instruction.
- instr_data  output  32  instruction word at the FIFO head.
- instr_pc  output  32  fetch address of instr_data, unmasked.
- instr_misalign  output  1  the head entry's pc had bits [1:0] != 00.
- instr_ready  input  1  decode stage pops the head.

## Operation
- FSM states: IDLE, REQ, WAIT, DRAIN. At most one memory request is outstanding.
- IDLE: pc_ready = !flush && count < DEPTH. When pc_valid && pc_ready, latch pc_in and go to REQ.
- REQ: mem_req_valid = 1, mem_req_addr = {latched[31:2], 2'b00}. When mem_req_ready is high, go to WAIT.
- WAIT: when mem_resp_valid is high, push {latched pc, mem_resp_data, latched[1:0] != 0} and go to IDLE.
- DRAIN: when mem_resp_valid is high, drop the data and go to IDLE.
- Once mem_req_valid is raised, it stays high until accepted; flush never withdraws it.
- Flush in IDLE: the state stays IDLE, no accept that cycle.
- Flush in REQ:
  - If mem_req_ready is high the same cycle, go to DRAIN.
  - Otherwise set a discard bit and stay in REQ. On acceptance, go to DRAIN instead of WAIT.
- Flush in WAIT: go to DRAIN. If mem_resp_valid is high the same cycle, drop it and go to IDLE.
- Flush in DRAIN: no effect.
- Flush always empties the FIFO (count = 0) on that edge. Any push or pop in the same cycle is suppressed.
- FIFO behaviour:
  - Push and pop in the same cycle leave count unchanged.
  - Head and tail pointers wrap modulo DEPTH.
  - A pop with instr_valid = 0 is ignored.
- Reserving the slot at accept time (count < DEPTH) guarantees the push never finds the FIFO full.
- mem_resp_valid in IDLE or REQ is a protocol error and is ignored.
- Reset values: state IDLE, count 0, pointers 0, discard 0. pc_ready 0 while reset is asserted. mem_req_valid 0, mem_req_addr 0, instr_valid 0, instr_data 0, instr_pc 0, instr_misalign 0.

## Timing
- pc_ready and mem_req_valid are decoded from registered state. instr_valid is registered (count != 0).
- instr_data, instr_pc and instr_misalign read the head entry.
- Sequence for pc accepted in cycle N:
  - mem_req_valid is high from N+1.
  - With mem_req_ready in N+1, the earliest response is N+2.
  - instr_valid is high in N+3.
  - The next pc accept is possible in N+3.
- Best-case throughput is one instruction per 3 cycles.
- Memory response latency is unbounded; WAIT holds indefinitely.
- pc_ready must not depend combinationally on pc_valid.

## Test plan
- Single fetch:
  - Stimulus: reset, then pc_in=0x00000004 with pc_valid. Memory is ready at once and responds with 0x00A00093 one cycle after accept.
  - Required: mem_req_addr=0x00000004 one cycle after accept, then instr_valid=1, instr_data=0x00A00093, instr_pc=0x00000004, instr_misalign=0.
- Backpressure:
  - Stimulus: instr_ready=0, fetch 0x0, 0x4, 0x8.
  - Required: two entries are buffered and pc_ready=0 with 0x8 pending. After one pop, 0x8 is accepted and returns last, in order.
- Stalled memory:
  - Stimulus: mem_req_ready low for 5 cycles.
  - Required: mem_req_valid and mem_req_addr are held stable all 5 cycles. The response is pushed only after acceptance.
- Flush in WAIT:
  - Stimulus: FIFO holds 1 entry, fetch of 0x10 is outstanding, pulse flush. Response 0xDEADBEEF arrives 2 cycles later.
  - Required: instr_valid=0 the cycle after flush, the response is discarded, and the next fetch 0x40 returns normally.
- Misaligned fetch and same-cycle pop:
  - Stimulus: fetch pc_in=0x00000106 while popping the head in the push cycle.
  - Required: mem_req_addr=0x00000104, instr_pc=0x00000106, instr_misalign=1, count unchanged by the push+pop.
- Reset mid-operation:
  - Stimulus: assert reset in WAIT with 2 entries buffered.
  - Required: the next cycle shows instr_valid=0, mem_req_valid=0, pc_ready=0 while reset is held. A late mem_resp_valid is ignored.
